uart_mem_bridge: RTL
====================

Name: uart_mem_bridge

Overview:
- Parametrised serial-to-memory command bridge between the uart_rx/uart_tx byte ports and the hyper_xface request port.
- Collects fixed-length command frames, executes them against memory, and returns a status-plus-data response frame.
- Generalises the original 4-byte command loop: configurable data width, address post-increment, memory and inter-byte timeouts, explicit error status.
- Response frames are exact length (no padding byte).

Parameters:
- DATA_BYTES, 4: payload/data width in bytes; DW = 8*DATA_BYTES; must be >= 1.
- ADDR_W, 32: memory address width; must be <= DW.
- ADDR_STEP, 2: added to addr after each WRITE/READ; 0 disables auto-increment.
- MEM_TIMEOUT, 1024: max cycles to wait for the memory handshake.
- RX_TIMEOUT, 65535: idle cycles after which a partial frame is discarded.
- ID_VALUE, 32'd259: value returned by the ID command; zero-extended or truncated to DW.

Ports:
- clk  in  1  system clock (hram_clk domain).
- reset  in  1  asynchronous, active-high reset.
- rx_rcv  in  1  one-cycle strobe: rx_data is valid.
- rx_data  in  8  received byte.
- tx_ready  in  1  uart_tx is idle.
- tx_start  out  1  one-cycle start strobe to uart_tx.
- tx_data  out  8  byte to transmit; stable while tx_start is high.
- mem_rd_req  out  1  read request pulse.
- mem_wr_req  out  1  write request pulse.
- mem_addr  out  ADDR_W  current address register.
- mem_wr_d  out  DW  write data register.
- mem_wr_byte_en  out  DATA_BYTES  constant all-ones.
- mem_rd_d  in  DW  read data.
- mem_rd_rdy  in  1  read data valid strobe.
- mem_busy  in  1  memory controller busy.
- rx_dropped  out  1  one-cycle pulse: a byte arrived while the block was not in COLLECT.
- frame_err  out  1  one-cycle pulse: partial frame discarded on RX timeout.

Behaviour:
- Reset values: all outputs 0 except mem_wr_byte_en, which is all-ones. addr, wr_d, frame counter, byte counter and timers are 0. State is COLLECT.
- Command frame: 1 command byte, then DATA_BYTES payload bytes, MSB first.
- Response frame: 1 status byte, then DATA_BYTES data bytes, MSB first.
- Status codes: 0x00 OK, 0xE1 unknown command, 0xE2 memory timeout.
- COLLECT:
  - Shift bytes in on rx_rcv.
  - The idle timer clears on each byte. If it reaches RX_TIMEOUT with byte count > 0, discard the frame and pulse frame_err.
  - On the final byte, go to EXEC on the next cycle.
- EXEC (one cycle), by command byte:
  - 0x01 SET_ADDR: addr <= payload[ADDR_W-1:0]; resp = payload.
  - 0x02 LOAD: wr_d <= payload; resp = payload.
  - 0x03 WRITE: go to MEM_ISSUE.
  - 0x04 READ: go to MEM_ISSUE.
  - 0x05 GET_ADDR: resp = addr, zero-extended.
  - 0x06 COUNT: resp = frame counter, then counter += 1. The counter is DW wide and wraps to 0.
  - 0x07 ID: resp = ID_VALUE.
  - Any other value: status 0xE1, resp = 0. Still a full-length response.
- MEM_ISSUE:
  - Wait for mem_busy = 0, then pulse mem_wr_req or mem_rd_req for exactly 1 cycle.
  - The MEM_TIMEOUT counter runs from entry to MEM_ISSUE.
- MEM_WAIT:
  - WRITE: wait for mem_busy to rise and then fall. resp = addr at issue time.
  - READ: wait for mem_rd_rdy; capture mem_rd_d into resp.
  - On success: addr <= addr + ADDR_STEP, modulo 2^ADDR_W.
  - On timeout: status 0xE2, resp = 0, addr unchanged, go to SEND. A late mem_rd_rdy is ignored.
- SEND:
  - When tx_ready = 1, drive tx_data and pulse tx_start for 1 cycle, then go to SEND_WAIT.
  - SEND_WAIT waits for tx_ready = 0, then returns to SEND with the next byte.
  - After DATA_BYTES+1 bytes, return to COLLECT.
  - tx_start is never high for two consecutive cycles.
- rx_rcv in any state other than COLLECT: byte dropped, rx_dropped pulses.
- Asynchronous reset mid-operation:
  - Request pulses and tx_start deassert immediately.
  - No partial response is resumed.
  - addr and wr_d clear.

Decomposition:
- Shared package uart_mem_pkg:
  - command byte constants CMD_SET_ADDR..CMD_ID;
  - status constants ST_OK, ST_BADCMD, ST_TIMEOUT;
  - state enum.
- One natural sub-module, uart_frame_ser: takes a (DATA_BYTES+1)-byte load plus a start, and runs the SEND/SEND_WAIT tx_ready handshake. The top keeps collect, exec and memory FSMs.

Test Plan:
- SET_ADDR: frame 01 00 00 00 10 -> mem_addr = 0x10; response 00 00 00 00 10 (exactly 5 bytes).
- Write: LOAD 02 DE AD BE EF, then WRITE 03 00 00 00 00; memory model busy for 6 cycles -> exactly one mem_wr_req pulse with wr_d = DEADBEEF, addr = 0x10; response 00 00 00 00 10; mem_addr becomes 0x12.
- Read: SET_ADDR 0x10, then READ 04 00 00 00 00; model returns rd_d = CAFEF00D after 9 cycles -> response 00 CA FE F0 0D; mem_addr = 0x12.
- Timeouts:
  - READ with the model never asserting mem_rd_rdy, MEM_TIMEOUT = 16 -> response E2 00 00 00 00 within about 20 cycles; addr unchanged.
  - Send 3 bytes, then idle RX_TIMEOUT cycles -> one frame_err pulse; the next full COUNT frame gets 00 00 00 00 00.
- Errors and counting:
  - Command 0x55 -> E1 00 00 00 00.
  - Two COUNT frames -> data 0 then 1.
  - A byte injected during SEND -> one rx_dropped pulse, and the response is unaltered.

Source files
------------

// File: rtl/uart_mem_pkg.sv
// Shared command, status and state definitions for the UART-to-memory bridge.
package uart_mem_pkg;

    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_LOAD     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_READ     = 8'h04;
    localparam logic [7:0] CMD_GET_ADDR = 8'h05;
    localparam logic [7:0] CMD_COUNT    = 8'h06;
    localparam logic [7:0] CMD_ID       = 8'h07;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BADCMD  = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hE2;

    // state        | meaning
    // S_COLLECT    | gathering command + payload bytes from uart_rx
    // S_EXEC       | decode command, update registers, pick response
    // S_MEM_ISSUE  | wait for memory idle, then issue request pulse
    // S_MEM_WAIT   | wait for write completion or read data
    // S_SEND       | response frame handed to the serialiser
    typedef enum logic [2:0] {
        S_COLLECT,
        S_EXEC,
        S_MEM_ISSUE,
        S_MEM_WAIT,
        S_SEND
    } bridge_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_SEND_WAIT
    } ser_state_t;

endpackage

// File: rtl/uart_frame_ser.sv
// Sends a (DATA_BYTES+1)-byte frame MSB first, one byte per uart_tx handshake.
module uart_frame_ser
    import uart_mem_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [8*(DATA_BYTES+1)-1:0]   frame,
    input  logic                          tx_ready,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    output logic                          done
);

    localparam int FW = 8*(DATA_BYTES+1);
    localparam int CW = $clog2(DATA_BYTES+2);

    ser_state_t      state;
    logic [FW-1:0]   shift;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SER_IDLE;
            shift    <= '0;
            cnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                SER_IDLE: begin
                    if (start) begin
                        shift <= frame;
                        cnt   <= '0;
                        state <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        tx_data  <= shift[FW-1 -: 8];
                        shift    <= {shift[FW-9:0], 8'h00};
                        state    <= SER_SEND_WAIT;
                    end
                end
                SER_SEND_WAIT: begin
                    // uart_tx drops tx_ready once it has accepted the byte
                    if (!tx_ready) begin
                        if (cnt == CW'(DATA_BYTES)) begin
                            done  <= 1'b1;
                            state <= SER_IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= SER_SEND;
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// Serial command bridge: collects command frames, runs them against memory,
// and returns a status byte plus DATA_BYTES of response data.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int          DATA_BYTES  = 4,
    parameter int          ADDR_W      = 32,
    parameter int          ADDR_STEP   = 2,
    parameter int          MEM_TIMEOUT = 1024,
    parameter int          RX_TIMEOUT  = 65535,
    parameter logic [31:0] ID_VALUE    = 32'd259
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_rcv,
    input  logic [7:0]              rx_data,
    input  logic                    tx_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wr_d,
    output logic [DATA_BYTES-1:0]   mem_wr_byte_en,
    input  logic [8*DATA_BYTES-1:0] mem_rd_d,
    input  logic                    mem_rd_rdy,
    input  logic                    mem_busy,
    output logic                    rx_dropped,
    output logic                    frame_err
);

    localparam int DW  = 8*DATA_BYTES;
    localparam int FW  = DW + 8;
    localparam int BCW = $clog2(DATA_BYTES+2);
    localparam int MTW = $clog2(MEM_TIMEOUT+1);
    localparam int RTW = $clog2(RX_TIMEOUT+1);

    bridge_state_t   state;
    logic [FW-1:0]   rx_shift;
    logic [BCW-1:0]  byte_cnt;
    logic [RTW-1:0]  rx_timer;
    logic [MTW-1:0]  mem_timer;
    logic [DW-1:0]   frame_cnt;
    logic [DW-1:0]   resp;
    logic [7:0]      status;
    logic            is_read;
    logic            seen_busy;
    logic            ser_start;
    logic            ser_done;
    logic [7:0]      cmd;
    logic [DW-1:0]   payload;

    assign cmd            = rx_shift[FW-1 -: 8];
    assign payload        = rx_shift[DW-1:0];
    assign mem_wr_byte_en = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_COLLECT;
            rx_shift   <= '0;
            byte_cnt   <= '0;
            rx_timer   <= '0;
            mem_timer  <= '0;
            frame_cnt  <= '0;
            resp       <= '0;
            status     <= ST_OK;
            is_read    <= 1'b0;
            seen_busy  <= 1'b0;
            ser_start  <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wr_d   <= '0;
            rx_dropped <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            ser_start  <= 1'b0;
            frame_err  <= 1'b0;
            rx_dropped <= rx_rcv && (state != S_COLLECT);

            if (state == S_MEM_ISSUE || state == S_MEM_WAIT) begin
                if (mem_timer != '0)
                    mem_timer <= mem_timer - 1'b1;
            end

            case (state)
                S_COLLECT: begin
                    if (rx_rcv) begin
                        rx_shift <= {rx_shift[FW-9:0], rx_data};
                        rx_timer <= RTW'(RX_TIMEOUT-1);
                        if (byte_cnt == BCW'(DATA_BYTES)) begin
                            byte_cnt <= '0;
                            state    <= S_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (byte_cnt != '0) begin
                        if (rx_timer == '0) begin
                            byte_cnt  <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            rx_timer <= rx_timer - 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    status    <= ST_OK;
                    ser_start <= 1'b1;
                    state     <= S_SEND;
                    case (cmd)
                        CMD_SET_ADDR: begin
                            mem_addr <= payload[ADDR_W-1:0];
                            resp     <= payload;
                        end
                        CMD_LOAD: begin
                            mem_wr_d <= payload;
                            resp     <= payload;
                        end
                        CMD_WRITE, CMD_READ: begin
                            ser_start <= 1'b0;
                            is_read   <= (cmd == CMD_READ);
                            mem_timer <= MTW'(MEM_TIMEOUT-1);
                            state     <= S_MEM_ISSUE;
                        end
                        CMD_GET_ADDR: resp <= DW'(mem_addr);
                        CMD_COUNT: begin
                            resp      <= frame_cnt;
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        CMD_ID: resp <= DW'(ID_VALUE);
                        default: begin
                            status <= ST_BADCMD;
                            resp   <= '0;
                        end
                    endcase
                end
                S_MEM_ISSUE: begin
                    if (!mem_busy) begin
                        mem_rd_req <= is_read;
                        mem_wr_req <= !is_read;
                        seen_busy  <= 1'b0;
                        state      <= S_MEM_WAIT;
                    end else if (mem_timer == '0) begin
                        status    <= ST_TIMEOUT;
                        resp      <= '0;
                        ser_start <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_MEM_WAIT: begin
                    if (is_read ? mem_rd_rdy : (seen_busy && !mem_busy)) begin
                        resp      <= is_read ? mem_rd_d : DW'(mem_addr);
                        mem_addr  <= mem_addr + ADDR_W'(ADDR_STEP);
                        ser_start <= 1'b1;
                        state     <= S_SEND;
                    end else if (mem_timer == '0) begin
                        status    <= ST_TIMEOUT;
                        resp      <= '0;
                        ser_start <= 1'b1;
                        state     <= S_SEND;
                    end else begin
                        seen_busy <= seen_busy | mem_busy;
                    end
                end
                S_SEND: begin
                    if (ser_done)
                        state <= S_COLLECT;
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    uart_frame_ser #(
        .DATA_BYTES (DATA_BYTES)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .start    (ser_start),
        .frame    ({status, resp}),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

endmodule
